// File: rtl/branch_predictor_bht_btb_if.sv
// Fetch/execute-side bus between the pipeline controller and the branch predictor.
// master = pipeline (drives PCs and resolution), slave = predictor.
interface branch_predictor_bht_btb_if #(
    parameter int AWIDTH = 32,
    parameter int CWIDTH = 32
);
    logic [AWIDTH-1:0] pc_f;
    logic              Br_f;
    logic [AWIDTH-1:0] pc_x;
    logic [AWIDTH-1:0] target_x;
    logic              Br_x;
    logic              BrTrue;
    logic              stall;
    logic              flush;
    logic              bp_en;
    logic              bp_clr;
    logic              BrPred;
    logic              Target_valid;
    logic [AWIDTH-1:0] Target;
    logic              BrPred_x;
    logic [CWIDTH-1:0] br_count;
    logic [CWIDTH-1:0] mispred_count;

    modport master (
        output pc_f, Br_f, pc_x, target_x, Br_x, BrTrue, stall, flush, bp_en, bp_clr,
        input  BrPred, Target_valid, Target, BrPred_x, br_count, mispred_count
    );

    modport slave (
        input  pc_f, Br_f, pc_x, target_x, Br_x, BrTrue, stall, flush, bp_en, bp_clr,
        output BrPred, Target_valid, Target, BrPred_x, br_count, mispred_count
    );
endinterface

// File: rtl/branch_predictor_bht_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters, combinational
// fetch lookup, X-stage training, and saturating branch/mispredict counters.
module branch_predictor_bht_btb #(
    parameter int AWIDTH   = 32,
    parameter int ENTRIES  = 16,
    parameter int CNT_BITS = 2,
    parameter int CWIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    branch_predictor_bht_btb_if.slave     bp
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = AWIDTH - IDX - 2;
    localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(2 ** (CNT_BITS - 1));

    logic                valid_all  [ENTRIES];
    logic [TAGW-1:0]     tag_all    [ENTRIES];
    logic [AWIDTH-1:0]   target_all [ENTRIES];
    logic [CNT_BITS-1:0] cnt_all    [ENTRIES];

    logic [IDX-1:0]  idx_f, idx_x;
    logic [TAGW-1:0] tag_f, tag_x;
    logic            hit_f, hit_x, train;
    logic            target_valid, br_pred;
    logic            brpred_x_reg;
    logic [CWIDTH-1:0] br_count_reg, mispred_count_reg;
    logic            unused_pc_lsbs;

    assign idx_f = bp.pc_f[IDX+1:2];
    assign tag_f = bp.pc_f[AWIDTH-1:IDX+2];
    assign idx_x = bp.pc_x[IDX+1:2];
    assign tag_x = bp.pc_x[AWIDTH-1:IDX+2];
    assign unused_pc_lsbs = ^{bp.pc_f[1:0], bp.pc_x[1:0]};

    // Lookup reads pre-update contents; there is intentionally no write bypass.
    assign hit_f        = valid_all[idx_f] && (tag_all[idx_f] == tag_f);
    assign hit_x        = valid_all[idx_x] && (tag_all[idx_x] == tag_x);
    assign target_valid = bp.bp_en && hit_f;
    assign br_pred      = target_valid && bp.Br_f && cnt_all[idx_f][CNT_BITS-1];
    assign train        = bp.Br_x && !bp.stall;

    assign bp.Target_valid  = target_valid;
    assign bp.BrPred        = br_pred;
    assign bp.Target        = target_valid ? target_all[idx_f] : '0;
    assign bp.BrPred_x      = brpred_x_reg;
    assign bp.br_count      = br_count_reg;
    assign bp.mispred_count = mispred_count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic                valid_reg;
            logic [TAGW-1:0]     tag_reg;
            logic [AWIDTH-1:0]   target_reg;
            logic [CNT_BITS-1:0] cnt_reg;
            logic                sel;

            assign sel = train && (idx_x == IDX'(gi));

            // Clear beats training: a same-cycle write to this entry is dropped.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    cnt_reg    <= '0;
                end else if (bp.bp_clr) begin
                    valid_reg <= 1'b0;
                end else if (sel) begin
                    if (hit_x) begin
                        if (bp.BrTrue) begin
                            target_reg <= bp.target_x;
                            if (cnt_reg != '1)
                                cnt_reg <= cnt_reg + CNT_BITS'(1);
                        end else if (cnt_reg != '0) begin
                            cnt_reg <= cnt_reg - CNT_BITS'(1);
                        end
                    end else if (bp.BrTrue) begin
                        valid_reg  <= 1'b1;
                        tag_reg    <= tag_x;
                        target_reg <= bp.target_x;
                        cnt_reg    <= CNT_WEAK;
                    end
                end
            end

            assign valid_all[gi]  = valid_reg;
            assign tag_all[gi]    = tag_reg;
            assign target_all[gi] = target_reg;
            assign cnt_all[gi]    = cnt_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brpred_x_reg      <= 1'b0;
            br_count_reg      <= '0;
            mispred_count_reg <= '0;
        end else begin
            if (!bp.stall)
                brpred_x_reg <= bp.flush ? 1'b0 : (br_pred && target_valid);
            if (train) begin
                if (br_count_reg != '1)
                    br_count_reg <= br_count_reg + CWIDTH'(1);
                if ((bp.BrTrue != brpred_x_reg) && (mispred_count_reg != '1))
                    mispred_count_reg <= mispred_count_reg + CWIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor_bht_btb.sv
// Directed bench for branch_predictor_bht_btb: one task per feature, hand-computed
// expectations, one line per checked transaction.
module tb_branch_predictor_bht_btb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    branch_predictor_bht_btb_if #(.AWIDTH(32), .CWIDTH(32)) bus ();

    branch_predictor_bht_btb #(.AWIDTH(32), .ENTRIES(16), .CNT_BITS(2), .CWIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.pc_f = 32'h100; bus.Br_f = 1'b1; bus.pc_x = '0; bus.target_x = '0;
        bus.Br_x = 1'b0; bus.BrTrue = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        bus.bp_en = 1'b1; bus.bp_clr = 1'b0;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.BrPred !== 1'b0 || bus.Target_valid !== 1'b0 || bus.Target !== 32'h0) begin
            failures++;
            $display("FAIL reset_lookup: BrPred=%b Target_valid=%b Target=%h required 0 0 0",
                     bus.BrPred, bus.Target_valid, bus.Target);
        end else $display("reset lookup pc_f=100 -> miss");
        tick;
        checks++;
        if (bus.BrPred_x !== 1'b0 || bus.br_count !== 32'd0 || bus.mispred_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_regs: BrPred_x=%b br=%0d mis=%0d required 0 0 0",
                     bus.BrPred_x, bus.br_count, bus.mispred_count);
        end else $display("reset regs BrPred_x=0 br=0 mis=0");
    endtask

    task automatic test_allocate;
        bus.pc_x = 32'h100; bus.target_x = 32'h80; bus.BrTrue = 1'b1; bus.Br_x = 1'b1;
        #1;
        checks++;
        if (bus.Target_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_bypass: Target_valid=%b required 0", bus.Target_valid);
        end else $display("same-cycle lookup sees pre-update miss");
        tick;
        bus.Br_x = 1'b0;
        #1;
        checks++;
        if (bus.Target_valid !== 1'b1 || bus.Target !== 32'h80 || bus.BrPred !== 1'b1) begin
            failures++;
            $display("FAIL allocate_lookup: Target_valid=%b Target=%h BrPred=%b required 1 80 1",
                     bus.Target_valid, bus.Target, bus.BrPred);
        end else $display("allocate 100->80 hit, BrPred=1");
        checks++;
        if (bus.br_count !== 32'd1 || bus.mispred_count !== 32'd1 || bus.BrPred_x !== 1'b0) begin
            failures++;
            $display("FAIL allocate_counts: br=%0d mis=%0d BrPred_x=%b required 1 1 0",
                     bus.br_count, bus.mispred_count, bus.BrPred_x);
        end else $display("allocate counts br=1 mis=1");
    endtask

    // Br_f is kept low at clock edges so BrPred_x stays 0, and raised only to peek at BrPred.
    task automatic test_counter;
        logic exp_pred [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic taken    [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bus.Br_f = 1'b0;
        bus.pc_x = 32'h100;
        for (int i = 0; i < 8; i++) begin
            bus.BrTrue   = taken[i];
            bus.target_x = taken[i] ? 32'h84 : 32'h999;
            bus.Br_x     = 1'b1;
            tick;
            bus.Br_x = 1'b0;
            bus.Br_f = 1'b1;
            #1;
            checks++;
            if (bus.BrPred !== exp_pred[i] || bus.Target_valid !== 1'b1) begin
                failures++;
                $display("FAIL counter_step%0d: BrPred=%b Target_valid=%b required %b 1",
                         i, bus.BrPred, bus.Target_valid, exp_pred[i]);
            end else $display("counter update %0d taken=%b -> BrPred=%b", i, taken[i], bus.BrPred);
            bus.Br_f = 1'b0;
        end
        #1;
        checks++;
        if (bus.Target !== 32'h84 || bus.br_count !== 32'd9 || bus.mispred_count !== 32'd5) begin
            failures++;
            $display("FAIL counter_totals: Target=%h br=%0d mis=%0d required 84 9 5",
                     bus.Target, bus.br_count, bus.mispred_count);
        end else $display("counter totals Target=84 br=9 mis=5");
    endtask

    task automatic test_alias;
        bus.pc_x = 32'h140; bus.target_x = 32'h200; bus.BrTrue = 1'b1; bus.Br_x = 1'b1;
        tick;
        bus.pc_x = 32'h104; bus.BrTrue = 1'b0;
        tick;
        bus.Br_x = 1'b0;
        bus.Br_f = 1'b1; bus.pc_f = 32'h100;
        #1;
        checks++;
        if (bus.Target_valid !== 1'b0 || bus.BrPred !== 1'b0) begin
            failures++;
            $display("FAIL alias_evicted: Target_valid=%b BrPred=%b required 0 0",
                     bus.Target_valid, bus.BrPred);
        end else $display("alias lookup 100 -> miss");
        bus.pc_f = 32'h140;
        #1;
        checks++;
        if (bus.Target_valid !== 1'b1 || bus.Target !== 32'h200 || bus.BrPred !== 1'b1) begin
            failures++;
            $display("FAIL alias_owner: Target_valid=%b Target=%h BrPred=%b required 1 200 1",
                     bus.Target_valid, bus.Target, bus.BrPred);
        end else $display("alias lookup 140 -> 200");
        bus.pc_f = 32'h104;
        #1;
        checks++;
        if (bus.Target_valid !== 1'b0 || bus.br_count !== 32'd11 || bus.mispred_count !== 32'd6) begin
            failures++;
            $display("FAIL nt_miss_no_alloc: Target_valid=%b br=%0d mis=%0d required 0 11 6",
                     bus.Target_valid, bus.br_count, bus.mispred_count);
        end else $display("not-taken miss 104 -> no allocation");
        bus.pc_f = 32'h140;
    endtask

    task automatic test_stall_flush;
        bus.Br_f = 1'b1; bus.Br_x = 1'b0;
        tick;
        checks++;
        if (bus.BrPred_x !== 1'b1) begin
            failures++;
            $display("FAIL brpred_x_load: BrPred_x=%b required 1", bus.BrPred_x);
        end else $display("BrPred_x loaded 1");
        bus.Br_f = 1'b0; bus.stall = 1'b1;
        bus.Br_x = 1'b1; bus.pc_x = 32'h140; bus.BrTrue = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.flush = (i == 2);
            tick;
            checks++;
            if (bus.BrPred_x !== 1'b1 || bus.br_count !== 32'd11) begin
                failures++;
                $display("FAIL stall_hold%0d: BrPred_x=%b br=%0d required 1 11",
                         i, bus.BrPred_x, bus.br_count);
            end else $display("stall cycle %0d flush=%b BrPred_x held", i, bus.flush);
        end
        bus.stall = 1'b0; bus.flush = 1'b0;
        tick;
        checks++;
        if (bus.br_count !== 32'd12 || bus.mispred_count !== 32'd7 || bus.BrPred_x !== 1'b0) begin
            failures++;
            $display("FAIL stall_release: br=%0d mis=%0d BrPred_x=%b required 12 7 0",
                     bus.br_count, bus.mispred_count, bus.BrPred_x);
        end else $display("stall release trained once br=12 mis=7");
        bus.BrTrue = 1'b1; bus.target_x = 32'h200; bus.Br_f = 1'b1;
        tick;
        bus.Br_x = 1'b0;
        #1;
        checks++;
        if (bus.BrPred !== 1'b1 || bus.mispred_count !== 32'd8) begin
            failures++;
            $display("FAIL single_write: BrPred=%b mis=%0d required 1 8", bus.BrPred, bus.mispred_count);
        end else $display("counter back to weakly taken: one stalled write only");
        tick;
        bus.flush = 1'b1;
        tick;
        checks++;
        if (bus.BrPred_x !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear: BrPred_x=%b required 0", bus.BrPred_x);
        end else $display("flush clears BrPred_x");
        bus.flush = 1'b0;
    endtask

    task automatic test_bp_en_clear;
        bus.Br_x = 1'b1; bus.pc_x = 32'h140; bus.BrTrue = 1'b1;
        tick;
        bus.Br_x = 1'b0; bus.bp_en = 1'b0;
        #1;
        checks++;
        if (bus.BrPred !== 1'b0 || bus.Target_valid !== 1'b0 || bus.Target !== 32'h0) begin
            failures++;
            $display("FAIL bp_en_off: BrPred=%b Target_valid=%b Target=%h required 0 0 0",
                     bus.BrPred, bus.Target_valid, bus.Target);
        end else $display("bp_en=0 forces not-taken");
        bus.Br_x = 1'b1; bus.pc_x = 32'h108; bus.target_x = 32'h300;
        tick;
        bus.Br_x = 1'b0; bus.bp_en = 1'b1; bus.pc_f = 32'h108;
        #1;
        checks++;
        if (bus.Target_valid !== 1'b1 || bus.Target !== 32'h300 || bus.br_count !== 32'd15 ||
            bus.mispred_count !== 32'd9) begin
            failures++;
            $display("FAIL train_while_off: Target_valid=%b Target=%h br=%0d mis=%0d required 1 300 15 9",
                     bus.Target_valid, bus.Target, bus.br_count, bus.mispred_count);
        end else $display("training with bp_en=0 allocated 108->300");
        bus.Br_x = 1'b1; bus.pc_x = 32'h10C; bus.target_x = 32'h400; bus.bp_clr = 1'b1;
        tick;
        bus.Br_x = 1'b0; bus.bp_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.pc_f = 32'h100 + 32'(i) * 32'h4 + ((i == 0) ? 32'h40 : 32'h0) + ((i == 1) ? 32'h4 : 32'h0);
            #1;
            checks++;
            if (bus.Target_valid !== 1'b0) begin
                failures++;
                $display("FAIL clear_pc%h: Target_valid=%b required 0", bus.pc_f, bus.Target_valid);
            end else $display("after clear pc_f=%h -> miss", bus.pc_f);
        end
        checks++;
        if (bus.br_count !== 32'd16 || bus.mispred_count !== 32'd10) begin
            failures++;
            $display("FAIL clear_counts: br=%0d mis=%0d required 16 10", bus.br_count, bus.mispred_count);
        end else $display("clear keeps perf counting br=16 mis=10");
    endtask

    task automatic test_async_reset;
        bus.Br_x = 1'b1; bus.pc_x = 32'h110; bus.target_x = 32'h500; bus.BrTrue = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.br_count !== 32'd0 || bus.mispred_count !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: br=%0d mis=%0d required 0 0", bus.br_count, bus.mispred_count);
        end else $display("async reset clears counters immediately");
        tick;
        bus.Br_x = 1'b0;
        rst = 1'b0;
        bus.pc_f = 32'h110;
        #1;
        checks++;
        if (bus.Target_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard: Target_valid=%b required 0", bus.Target_valid);
        end else $display("update during reset discarded");
    endtask

    initial begin
        test_reset;
        test_allocate;
        test_counter;
        test_alias;
        test_stall_flush;
        test_bp_en_clear;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_predictor_bht_btb.md
# branch_predictor_bht_btb

- Parametrised dynamic branch predictor for the pipelined RISC-V core.
- Combines a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters (BHT).
- Looks up the fetch PC combinationally to drive the controller's `BrPred`/`Target_valid` inputs, registers the F-stage prediction forward as `BrPred_x`, and trains from resolved X-stage branches.
- Adds saturating branch/mispredict performance counters and a synchronous table-clear.

## Interface
Parameters:
- `AWIDTH`, 32: PC/target width.
- `ENTRIES`, 16: table depth; power of two, ≥2. `IDX = log2(ENTRIES)`.
- `CNT_BITS`, 2: direction counter width, ≥1.
- `CWIDTH`, 32: performance counter width.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_f`  in  AWIDTH  fetch-stage PC.
- `Br_f`  in  1  fetch instruction is a conditional branch.
- `pc_x`  in  AWIDTH  X-stage PC.
- `target_x`  in  AWIDTH  X-stage computed branch target.
- `Br_x`  in  1  X instruction is a conditional branch.
- `BrTrue`  in  1  X branch resolved taken.
- `stall`  in  1  pipeline hold (load-use).
- `flush`  in  1  F/X squash.
- `bp_en`  in  1  prediction enable; 0 forces static not-taken.
- `bp_clr`  in  1  synchronous invalidate of all entries.
- `BrPred`  out  1  predict taken.
- `Target_valid`  out  1  BTB hit for `pc_f`.
- `Target`  out  AWIDTH  predicted target.
- `BrPred_x`  out  1  prediction that accompanied the X instruction.
- `br_count`  out  CWIDTH  resolved branches.
- `mispred_count`  out  CWIDTH  mispredicted branches.

## Operation
Entry contents:
- Each entry holds `valid`, `tag = pc[AWIDTH-1:IDX+2]`, `target[AWIDTH-1:0]` and `cnt[CNT_BITS-1:0]`.
- Index is `pc[IDX+1:2]`; `pc[1:0]` is ignored.

Lookup (combinational):
- `hit_f = valid[idx_f] & tag match`.
- `Target_valid = bp_en & hit_f`.
- `BrPred = bp_en & hit_f & Br_f & cnt[idx_f][CNT_BITS-1]`.
- `Target = Target_valid ? target[idx_f] : 0`.

Prediction pipeline register:
- If `stall`: `BrPred_x` holds.
- Else if `flush`: `BrPred_x <= 0`.
- Else: `BrPred_x <= BrPred & Target_valid`.

Training (active when `Br_x & !stall`):
- Hit at `pc_x`, taken: `cnt` increments, saturating at all-ones; `target <= target_x`.
- Hit at `pc_x`, not taken: `cnt` decrements, saturating at 0; target unchanged.
- Miss, taken: allocate the entry, overwriting any victim: `valid <= 1`, tag, `target <= target_x`, `cnt <= 2^(CNT_BITS-1)` (weakly taken).
- Miss, not taken: no write.
- Training proceeds regardless of `flush` and regardless of `bp_en`.

Clear:
- `bp_clr` zeroes every `valid` bit next edge.
- `bp_clr` takes priority over a same-cycle training write; that write is dropped.
- Counters and `BrPred_x` are unaffected by `bp_clr`.

Performance counters:
- When `Br_x & !stall`: `br_count` increments.
- `mispred_count` also increments if `BrTrue != BrPred_x`.
- Both saturate at all-ones.

## Timing
- Lookup latency is 0 cycles (combinational from `pc_f`).
- Training is visible to lookups from the cycle after the update edge.
- Same-cycle lookup and training at the same index: lookup returns pre-update contents; there is no bypass.
- Reset values:
  - all `valid=0`, `cnt=0`, `target=0`
  - `BrPred_x=0`, `br_count=0`, `mispred_count=0`
  - hence `BrPred=0`, `Target_valid=0`, `Target=0`.
- Reset is asserted asynchronously and released synchronously by the surrounding reset logic. Reset mid-update discards the update.
- `stall` and `flush` together: `stall` wins and `BrPred_x` holds.
- `ENTRIES` wrap-around: PCs differing only above bit `IDX+1` alias to one index and are distinguished only by tag. The last writer owns the entry.

## Test plan
- Reset, then `pc_f=0x100`, `Br_f=1` → `BrPred=0`, `Target_valid=0`, `Target=0`; `BrPred_x=0` after one edge; both perf counters 0.
- Train `pc_x=0x100`, `target_x=0x80`, `BrTrue=1`, `Br_x=1` for one cycle → next cycle `pc_f=0x100` gives `Target_valid=1`, `Target=0x80`, `BrPred=1` (cnt=2); `br_count=1`, `mispred_count=1`.
- Same entry: two not-taken updates → cnt 2→1→0, `BrPred=0`, `Target_valid=1`. Three taken updates → cnt 0→1→2→3 (saturated). A fourth taken update keeps cnt at 3.
- Alias: allocate `0x100`, then taken branch at `0x100 + 4*ENTRIES` with target `0x200` → lookup of `0x100` misses; lookup of the alias hits with `Target=0x200`.
- `stall=1` with `Br_x=1` for 3 cycles, then `stall=0` → exactly one training write and `br_count` +1; `BrPred_x` held throughout. Then `flush=1` → `BrPred_x=0` next edge.
- `bp_en=0` with a valid, strongly-taken entry → `BrPred=0`, `Target_valid=0`. Training continues. Then `bp_clr=1` together with a taken update → all entries invalid next cycle, the update is dropped, and perf counters still increment.
